// File: rtl/seq_add_mul_unit.sv
// Sequential add / shift-and-add multiply unit with valid/ready handshakes on both sides.
// Optional two's-complement operation is enabled by defining SEQ_ADD_MUL_SIGNED_EN.
module seq_add_mul_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SEQ_ADD_MUL_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
`ifdef SEQ_ADD_MUL_SIGNED_EN
    ,NEG = 2'd3
`endif
  } state_t;

  state_t               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic [RW-1:0]        result_q;
  logic [RW-1:0]        acc_q;
  logic [RW-1:0]        mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [RW-1:0]        sum_d;
  logic [RW-1:0]        add_d;
  logic [WIDTH-1:0]     mcand_d;
  logic [WIDTH-1:0]     mplier_d;

  // Unsigned add: carry lands in bit WIDTH, everything above stays zero.
  function automatic logic [RW-1:0] add_unsigned(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return {{(WIDTH-1){1'b0}}, s};
  endfunction

`ifdef SEQ_ADD_MUL_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]    ONE_RW = {{(RW-1){1'b0}}, 1'b1};

  logic sgn_q;
  logic neg_q;
  logic neg_d;

  function automatic logic [RW-1:0] sext(input logic [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + ONE_W) : x;
  endfunction

  function automatic logic [RW-1:0] negate(input logic [RW-1:0] x);
    return ~x + ONE_RW;
  endfunction
`endif

  always_comb begin
    sum_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    add_d    = add_unsigned(a, b);
    mcand_d  = a;
    mplier_d = b;
`ifdef SEQ_ADD_MUL_SIGNED_EN
    neg_d    = 1'b0;
    if (is_signed) begin
      add_d    = sext(a) + sext(b);
      mcand_d  = mag(a);
      mplier_d = mag(b);
      neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`ifdef SEQ_ADD_MUL_SIGNED_EN
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (mode) begin
              result_q    <= add_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, mcand_d};
              mplier_q <= mplier_d;
              cnt_q    <= CNT_LOAD;
              busy_q   <= 1'b1;
              state_q  <= MUL;
`ifdef SEQ_ADD_MUL_SIGNED_EN
              sgn_q    <= is_signed;
              neg_q    <= neg_d;
`endif
            end
          end
        end
        // One partial product per cycle; the multiplicand walks left instead of a variable shift.
        MUL: begin
          acc_q    <= sum_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            busy_q <= 1'b0;
`ifdef SEQ_ADD_MUL_SIGNED_EN
            if (sgn_q) begin
              state_q <= NEG;
            end else begin
              result_q    <= sum_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
`else
            result_q    <= sum_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`endif
          end
        end
`ifdef SEQ_ADD_MUL_SIGNED_EN
        // Signed multiplies always pass through here so their latency does not depend on data.
        NEG: begin
          result_q    <= neg_q ? negate(acc_q) : acc_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_add_mul_unit.sv
// Bench for seq_add_mul_unit: WIDTH=4 and WIDTH=8 instances against an arithmetic reference model.
module tb_seq_add_mul_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv4, iv8;
  logic        mode;
  logic [7:0]  a_s, b_s;
  logic        sgn;
  logic        out_ready;

  logic        rdy4, ov4, busy4;
  logic [7:0]  res4;
  logic        rdy8, ov8, busy8;
  logic [15:0] res8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_add_mul_unit #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .in_ready  (rdy4),
    .mode      (mode),
    .a         (a_s[3:0]),
    .b         (b_s[3:0]),
`ifdef SEQ_ADD_MUL_SIGNED_EN
    .is_signed (sgn),
`endif
    .out_valid (ov4),
    .out_ready (out_ready),
    .result    (res4),
    .busy      (busy4)
  );

  seq_add_mul_unit #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (rdy8),
    .mode      (mode),
    .a         (a_s),
    .b         (b_s),
`ifdef SEQ_ADD_MUL_SIGNED_EN
    .is_signed (sgn),
`endif
    .out_valid (ov8),
    .out_ready (out_ready),
    .result    (res8),
    .busy      (busy8)
  );

  // Reference: plain integer arithmetic on the operand values, truncated to 2*w bits.
  function automatic logic [15:0] model(input int w, input bit m, input logic [7:0] x,
                                        input logic [7:0] y, input bit s);
    int xv, yv, r;
    xv = int'(x) & ((1 << w) - 1);
    yv = int'(y) & ((1 << w) - 1);
    if (s && xv >= (1 << (w - 1))) xv = xv - (1 << w);
    if (s && yv >= (1 << (w - 1))) yv = yv - (1 << w);
    r = m ? (xv + yv) : (xv * yv);
    return 16'(r & ((1 << (2 * w)) - 1));
  endfunction

  function automatic int exp_lat(input int w, input bit m, input bit s);
    if (m) return 1;
    return s ? w + 2 : w + 1;
  endfunction

  // Presents one operation, waits for acceptance and then for out_valid (both bounded).
  task automatic op(input int w, input bit m, input logic [7:0] x, input logic [7:0] y,
                    input bit s, output logic [15:0] res, output int lat, output int bc);
    int guard;
    mode = m; a_s = x; b_s = y; sgn = s;
    if (w == 4) iv4 = 1'b1; else iv8 = 1'b1;
    guard = 0;
    while (!(w == 4 ? rdy4 : rdy8) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    iv4 = 1'b0; iv8 = 1'b0;
    lat = 1; bc = 0;
    while (!(w == 4 ? ov4 : ov8) && lat < 60) begin
      bc += int'(w == 4 ? busy4 : busy8);
      @(posedge clk); #1; lat++;
    end
    res = (w == 4) ? {8'h00, res4} : res8;
  endtask

  task automatic consume(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; iv4 = 0; iv8 = 0; mode = 0; a_s = 0; b_s = 0; sgn = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", rdy4); end
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", ov4); end
    checks++; if (res4 !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", res4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy4); end
    checks++; if (res8 !== 16'h0000 || rdy8 !== 1'b1) begin
      failures++; $display("FAIL reset_w8 result=%h in_ready=%0b exp=0000/1", res8, rdy8);
    end
  endtask

  task automatic test_mul_basic;
    logic [15:0] r; int lat, bc;
    out_ready = 1'b1;
    op(4, 1'b0, 8'd15, 8'd15, 1'b0, r, lat, bc);
    checks++; if (r !== 16'd225) begin failures++; $display("FAIL mul15x15 got=%0d exp=225", r); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL mul_latency got=%0d exp=5", lat); end
    checks++; if (bc !== 4) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=4", bc); end
    consume(0);
  endtask

  task automatic test_add_basic;
    logic [15:0] r; int lat, bc;
    op(4, 1'b1, 8'd15, 8'd15, 1'b0, r, lat, bc);
    checks++; if (r !== 16'd30) begin failures++; $display("FAIL add15p15 got=%0d exp=30", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    consume(1);
    op(4, 1'b1, 8'd3, 8'd5, 1'b0, r, lat, bc);
    checks++; if (r !== 16'd8) begin failures++; $display("FAIL add3p5 got=%0d exp=8", r); end
    consume(0);
    checks++; if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin
      failures++; $display("FAIL add_release out_valid=%0b in_ready=%0b exp=0/1", ov4, rdy4);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] r; int lat, bc;
    out_ready = 1'b0;
    op(4, 1'b0, 8'd6, 8'd7, 1'b0, r, lat, bc);
    checks++; if (r !== 16'd42 || lat !== 5) begin
      failures++; $display("FAIL bp_mul got=%0d lat=%0d exp=42 lat=5", r, lat);
    end
    // Stray request while held in DONE must be ignored.
    mode = 1'b1; a_s = 8'd9; b_s = 8'd9; iv4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov4 !== 1'b1 || res4 !== 8'd42 || rdy4 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d out_valid=%0b result=%0d in_ready=%0b exp=1/42/0", i, ov4, res4, rdy4);
      end
    end
    iv4 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (rdy4 !== 1'b1 || ov4 !== 1'b0 || res4 !== 8'd42) begin
      failures++; $display("FAIL bp_release in_ready=%0b out_valid=%0b result=%0d exp=1/0/42", rdy4, ov4, res4);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] r; int lat, bc;
    out_ready = 1'b0;
    mode = 1'b0; a_s = 8'd9; b_s = 8'd9; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0b exp=1", busy4); end
    rst_n = 1'b0;
    #1;
    checks++; if (ov4 !== 1'b0 || res4 !== 8'h00 || busy4 !== 1'b0 || rdy4 !== 1'b1) begin
      failures++;
      $display("FAIL midrst_clear out_valid=%0b result=%h busy=%0b in_ready=%0b exp=0/00/0/1", ov4, res4, busy4, rdy4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL midrst_no_pulse got=%0b exp=0", ov4); end
    op(4, 1'b0, 8'd3, 8'd4, 1'b0, r, lat, bc);
    checks++; if (r !== 16'd12 || lat !== 5) begin
      failures++; $display("FAIL midrst_mul got=%0d lat=%0d exp=12 lat=5", r, lat);
    end
    consume(0);
  endtask

  task automatic test_wide;
    logic [15:0] r; int lat, bc;
    op(8, 1'b0, 8'd255, 8'd255, 1'b0, r, lat, bc);
    checks++; if (r !== 16'd65025 || lat !== 9) begin
      failures++; $display("FAIL w8_mul255 got=%0d lat=%0d exp=65025 lat=9", r, lat);
    end
    consume(0);
    op(8, 1'b0, 8'd0, 8'd200, 1'b0, r, lat, bc);
    checks++; if (r !== 16'd0 || lat !== 9 || bc !== 8) begin
      failures++; $display("FAIL w8_mul_zero got=%0d lat=%0d busy=%0d exp=0 lat=9 busy=8", r, lat, bc);
    end
    consume(0);
  endtask

`ifdef SEQ_ADD_MUL_SIGNED_EN
  task automatic test_signed;
    logic [15:0] r; int lat, bc;
    op(4, 1'b0, 8'h0D, 8'h05, 1'b1, r, lat, bc);
    checks++; if (r !== 16'h00F1 || lat !== 6) begin
      failures++; $display("FAIL s_mul_m3x5 got=%h lat=%0d exp=00F1 lat=6", r, lat);
    end
    consume(0);
    op(4, 1'b1, 8'h08, 8'h0F, 1'b1, r, lat, bc);
    checks++; if (r !== 16'h00F7 || lat !== 1) begin
      failures++; $display("FAIL s_add_m8m1 got=%h lat=%0d exp=00F7 lat=1", r, lat);
    end
    consume(0);
    op(8, 1'b0, 8'h80, 8'h80, 1'b1, r, lat, bc);
    checks++; if (r !== 16'h4000 || lat !== 10) begin
      failures++; $display("FAIL s_mul_min got=%h lat=%0d exp=4000 lat=10", r, lat);
    end
    consume(0);
  endtask
`endif

  task automatic test_random;
    logic [15:0] r, e; int lat, bc, w; bit m, s; logic [7:0] x, y;
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 1) == 0) ? 4 : 8;
      m = 1'($urandom_range(0, 1));
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      if (w == 4) begin x = x & 8'h0F; y = y & 8'h0F; end
`ifdef SEQ_ADD_MUL_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      out_ready = 1'($urandom_range(0, 1));
      op(w, m, x, y, s, r, lat, bc);
      e = model(w, m, x, y, s);
      checks++;
      if (r !== e || lat !== exp_lat(w, m, s)) begin
        failures++;
        $display("FAIL rand%0d w=%0d m=%0b s=%0b a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                 i, w, m, s, x, y, r, lat, e, exp_lat(w, m, s));
      end
      consume($urandom_range(0, 3));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_add_basic();
    test_backpressure();
    test_reset_mid();
    test_wide();
`ifdef SEQ_ADD_MUL_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_add_mul_unit.md
Name: seq_add_mul_unit

Overview:
Parametrised, sequential successor to the team's 3-bit combinational adder/multiplier pair. It takes two WIDTH-bit operands and a mode bit through a valid/ready handshake. Add completes in one cycle; multiply runs an iterative shift-and-add over WIDTH cycles. Holds the full 2*WIDTH-bit result until the consumer accepts it. Sits between the tile's input pins and output mux and replaces the fixed 3-bit datapath.

Parameters:
WIDTH, 4, operand width in bits (legal 2..16); result is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), width of the internal iteration counter (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands and mode present
in_ready  output  1  unit can accept an operation (high only in IDLE)
mode  input  1  1 = add, 0 = multiply (same polarity as the existing Enable select)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  add: zero-extended {carry, sum}; multiply: full product
busy  output  1  high in MUL state

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, out_valid=0, result=0, busy=0, counter=0, operand registers=0. in_ready=1 once the FSM is in IDLE.
- FSM has three states: IDLE, MUL and DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b and mode.
  - mode=1: result <= a+b, computed in WIDTH+1 bits and zero-extended to 2*WIDTH. Go to DONE.
  - mode=0: clear the accumulator, load multiplicand=a and multiplier=b, set counter=WIDTH, go to MUL.
- MUL: each cycle, if multiplier[0] then accumulator += multiplicand<<(WIDTH-counter). Then shift the multiplier right and decrement the counter. When counter reaches 1 on a cycle, write the final sum to result and go to DONE. Exactly WIDTH cycles are spent in MUL.
- DONE: out_valid=1 and result stable. On out_ready, clear out_valid and go to IDLE. result holds its last value until the next completion.
- Latency, counted from the accept edge to the first cycle with out_valid high:
  - add: 1 cycle
  - multiply: WIDTH+1 cycles
- No overlap: in_ready=0 in MUL and DONE, so there is one IDLE cycle minimum between operations.
- in_valid while not ready: ignored, no side effects. The producer must hold its data until accepted.
- out_ready while out_valid=0: ignored.
- Backpressure: DONE persists indefinitely with result unchanged while out_ready=0.
- Zero operand in multiply: still takes WIDTH cycles; result=0.
- Widths: the multiply accumulator is 2*WIDTH bits and never overflows. The add carry lands in result[WIDTH]. Bits above WIDTH are 0 for add.
- Reset mid-operation (MUL or DONE): immediate return to IDLE with all reset values. The partial result is discarded and no out_valid pulse is issued.

Optional Feature:
Macro SEQ_ADD_MUL_SIGNED_EN.
- Defined: adds input port is_signed (1 bit), latched with the operands.
- When is_signed=1, a and b are two's complement.
  - add: operands are sign-extended to 2*WIDTH and summed.
  - multiply: magnitudes are multiplied, then the product is negated if the signs differ. Negation costs one extra cycle in a NEG state, so multiply latency is WIDTH+2 cycles.
- When is_signed=0, behaviour and latency are identical to the undefined build.
- Undefined: no is_signed port, no NEG state, unsigned only.

Test Plan:
- WIDTH=4, multiply: a=15, b=15, out_ready=1 -> out_valid exactly 5 cycles after accept, result=225 (8'hE1); busy high for 4 cycles.
- WIDTH=4, add: a=15, b=15 -> out_valid 1 cycle after accept, result=30 (8'h1E); then add a=3, b=5 -> result=8.
- Backpressure: a=6, b=7 multiply with out_ready=0 for 10 cycles -> result=42 held stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
- Reset mid-multiply: assert rst_n=0 two cycles into MUL -> out_valid, result and busy go to 0 immediately; after release a new multiply 3*4 returns 12.
- WIDTH=8: a=255, b=255 multiply -> result=65025 after 9 cycles; a=0, b=200 -> result=0 after 9 cycles.
- SEQ_ADD_MUL_SIGNED_EN, WIDTH=4, is_signed=1:
  - a=-3 (4'hD), b=5 multiply -> result=-15 (8'hF1) after 6 cycles.
  - a=-8, b=-1 add -> result=-9 (8'hF7).
